// File: rtl/q_update_ctrl.sv
// Q-learning update sequencer: reads Q(s,a), scans Q(s',*) for the legal max,
// hands operands to an external update datapath and writes the result back.
module q_update_ctrl #(
    parameter int SW   = 15,
    parameter int NACT = 9,
    localparam int AW  = SW + 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] cur_state,
    input  logic [3:0]    action,
    input  logic [SW-1:0] next_state,
    input  logic          terminal,
    input  logic [8:0]    act_mask,
    input  logic [15:0]   reward,
    input  logic [3:0]    gamma,
    input  logic [3:0]    alfa,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [15:0]   mem_rd_data,
    output logic          mem_wr_en,
    output logic [15:0]   mem_wr_data,
    output logic [15:0]   upd_q,
    output logic [15:0]   upd_max_q,
    output logic [15:0]   upd_reward,
    output logic [3:0]    upd_gamma,
    output logic [3:0]    upd_alfa,
    input  logic [15:0]   upd_q_new,
    output logic          busy,
    output logic          done,
    output logic [15:0]   max_q_out
);
    typedef enum logic [2:0] {S_IDLE, S_RD_Q, S_SCAN, S_DRAIN, S_UPD, S_WR, S_DONE} state_t;

    localparam logic [3:0] LAST_ACT = 4'(NACT - 1);

    state_t        r_state;
    logic [SW-1:0] r_cur_state, r_next_state;
    logic [3:0]    r_action, r_gamma, r_alfa, r_idx, r_cap_act;
    logic          r_terminal, r_cap_q, r_cap_scan;
    logic [8:0]    r_mask;
    logic [15:0]   r_reward, r_q, r_max;
    logic          r_mem_rd_en, r_mem_wr_en, r_busy, r_done;
    logic [AW-1:0] r_mem_addr;
    logic [15:0]   r_mem_wr_data, r_upd_q, r_upd_max_q, r_upd_reward, r_max_q_out;
    logic [3:0]    r_upd_gamma, r_upd_alfa;

    logic          w_scan_hit;
    logic [15:0]   w_max_next, w_q_next, w_max_q;
    logic [3:0]    w_idx_inc;

    // Read data arrives one cycle after issue; r_cap_* tag what the current mem_rd_data is.
    assign w_scan_hit = r_cap_scan && r_mask[r_cap_act] && ($signed(mem_rd_data) > $signed(r_max));
    assign w_max_next = w_scan_hit ? mem_rd_data : r_max;
    assign w_q_next   = r_cap_q ? mem_rd_data : r_q;
    assign w_max_q    = (r_terminal || (r_mask == 9'd0)) ? 16'h0000 : w_max_next;
    assign w_idx_inc  = r_idx + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cur_state   <= '0;
            r_next_state  <= '0;
            r_action      <= '0;
            r_gamma       <= '0;
            r_alfa        <= '0;
            r_idx         <= '0;
            r_cap_act     <= '0;
            r_terminal    <= 1'b0;
            r_cap_q       <= 1'b0;
            r_cap_scan    <= 1'b0;
            r_mask        <= '0;
            r_reward      <= '0;
            r_q           <= '0;
            r_max         <= 16'h8000;
            r_mem_rd_en   <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_upd_q       <= '0;
            r_upd_max_q   <= '0;
            r_upd_reward  <= '0;
            r_upd_gamma   <= '0;
            r_upd_alfa    <= '0;
            r_max_q_out   <= '0;
        end else begin
            r_cap_q    <= r_mem_rd_en && (r_state == S_RD_Q);
            r_cap_scan <= r_mem_rd_en && (r_state == S_SCAN);
            r_cap_act  <= r_mem_addr[3:0];
            r_q        <= w_q_next;
            r_max      <= w_max_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_cur_state  <= cur_state;
                    r_action     <= action;
                    r_next_state <= next_state;
                    r_terminal   <= terminal;
                    r_mask       <= act_mask;
                    r_reward     <= reward;
                    r_gamma      <= gamma;
                    r_alfa       <= alfa;
                    r_max        <= 16'h8000;
                    r_busy       <= 1'b1;
                    r_mem_rd_en  <= 1'b1;
                    r_mem_addr   <= {cur_state, action};
                    r_state      <= S_RD_Q;
                end
                S_RD_Q: if (r_terminal) begin
                    r_mem_rd_en <= 1'b0;
                    r_state     <= S_DRAIN;
                end else begin
                    r_mem_addr <= {r_next_state, 4'd0};
                    r_idx      <= 4'd0;
                    r_state    <= S_SCAN;
                end
                // Every action is read regardless of mask so latency stays fixed.
                S_SCAN: if (r_idx == LAST_ACT) begin
                    r_mem_rd_en <= 1'b0;
                    r_state     <= S_DRAIN;
                end else begin
                    r_idx      <= w_idx_inc;
                    r_mem_addr <= {r_next_state, w_idx_inc};
                end
                S_DRAIN: begin
                    r_upd_q      <= w_q_next;
                    r_upd_max_q  <= w_max_q;
                    r_upd_reward <= r_reward;
                    r_upd_gamma  <= r_gamma;
                    r_upd_alfa   <= r_alfa;
                    r_state      <= S_UPD;
                end
                S_UPD: begin
                    r_mem_wr_en   <= 1'b1;
                    r_mem_wr_data <= upd_q_new;
                    r_mem_addr    <= {r_cur_state, r_action};
                    r_state       <= S_WR;
                end
                S_WR: begin
                    r_mem_wr_en <= 1'b0;
                    r_done      <= 1'b1;
                    r_max_q_out <= r_upd_max_q;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_wr_data = r_mem_wr_data;
    assign upd_q       = r_upd_q;
    assign upd_max_q   = r_upd_max_q;
    assign upd_reward  = r_upd_reward;
    assign upd_gamma   = r_upd_gamma;
    assign upd_alfa    = r_upd_alfa;
    assign busy        = r_busy;
    assign done        = r_done;
    assign max_q_out   = r_max_q_out;

endmodule

// File: tb/tb_q_update_ctrl.sv
// Directed bench for q_update_ctrl: one-cycle-latency memory model plus a simple
// additive update datapath (q + max + reward + {gamma,alfa}).
module tb_q_update_ctrl;
    localparam int SW = 15;
    localparam int AW = SW + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] cur_state = '0, next_state = '0;
    logic [3:0]    action = '0, gamma = '0, alfa = '0;
    logic          terminal = 1'b0;
    logic [8:0]    act_mask = '0;
    logic [15:0]   reward = '0;
    logic          mem_rd_en, mem_wr_en, busy, done;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rd_data = '0;
    logic [15:0]   mem_wr_data, upd_q, upd_max_q, upd_reward, max_q_out, upd_q_new;
    logic [3:0]    upd_gamma, upd_alfa;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, t0 = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, both_cnt = 0, wr_cyc = -1, done_cyc = -1;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic [15:0]   mem [int];
    int            vals [9];

    q_update_ctrl #(.SW(SW), .NACT(9)) dut (
        .clk(clk), .rst(rst), .start(start), .cur_state(cur_state), .action(action),
        .next_state(next_state), .terminal(terminal), .act_mask(act_mask), .reward(reward),
        .gamma(gamma), .alfa(alfa), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .upd_q(upd_q), .upd_max_q(upd_max_q), .upd_reward(upd_reward), .upd_gamma(upd_gamma),
        .upd_alfa(upd_alfa), .upd_q_new(upd_q_new), .busy(busy), .done(done), .max_q_out(max_q_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign upd_q_new = upd_q + upd_max_q + upd_reward + {8'd0, upd_gamma, upd_alfa};

    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 16'h0000;

    always @(negedge clk) begin
        if (mem_rd_en) rd_cnt++;
        if (mem_wr_en) begin
            wr_cnt++;
            wr_cyc  = cyc - t0;
            wr_addr = mem_addr;
            wr_data = mem_wr_data;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc - t0;
        end
        if (mem_rd_en && mem_wr_en) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_next(input logic [SW-1:0] ns);
        for (int a = 0; a < 9; a++) mem[int'({ns, 4'(a)})] = 16'(vals[a]);
    endtask

    task automatic drive_start(input logic [SW-1:0] cs, input logic [3:0] ac, input logic [SW-1:0] ns,
                               input logic term, input logic [8:0] mask, input logic [15:0] rw);
        @(posedge clk); #1;
        cur_state = cs; action = ac; next_state = ns; terminal = term;
        act_mask = mask; reward = rw; gamma = 4'h3; alfa = 4'h2;
        start = 1'b1;
        t0 = cyc;
    endtask

    task automatic run_op(input string tag, input logic [SW-1:0] ns, input logic term,
                          input logic [8:0] mask, input logic [15:0] rw, input int second,
                          input logic [15:0] exp_max, input logic [15:0] exp_wdata);
        int wr0, rd0, dn0, bo0;
        wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; bo0 = both_cnt;
        drive_start(15'h0123, 4'd4, ns, term, mask, rw);
        for (int i = 1; i <= 40 && done_cnt == dn0; i++) begin
            @(posedge clk); #1;
            start = (i == second);
            if (start) begin
                cur_state = 15'h0777; action = 4'd1; terminal = ~term; act_mask = 9'h000;
            end
            if (i == 1) chk({tag, ".busy_active"}, 32'(busy), 32'd1);
        end
        start = 1'b0;
        chk({tag, ".done_count"}, done_cnt - dn0, 1);
        chk({tag, ".write_count"}, wr_cnt - wr0, 1);
        chk({tag, ".read_count"}, rd_cnt - rd0, term ? 1 : 10);
        chk({tag, ".rd_wr_overlap"}, both_cnt - bo0, 0);
        chk({tag, ".write_cycle"}, wr_cyc, term ? 4 : 13);
        chk({tag, ".done_cycle"}, done_cyc, term ? 5 : 14);
        chk({tag, ".write_addr"}, 32'(wr_addr), 32'h1234);
        chk({tag, ".write_data"}, 32'(wr_data), 32'(exp_wdata));
        chk({tag, ".upd_q"}, 32'(upd_q), 32'd100);
        chk({tag, ".upd_max_q"}, 32'(upd_max_q), 32'(exp_max));
        chk({tag, ".upd_reward"}, 32'(upd_reward), 32'(rw));
        chk({tag, ".max_q_out"}, 32'(max_q_out), 32'(exp_max));
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".rd_en"}, 32'(mem_rd_en), 0);
        chk({tag, ".wr_en"}, 32'(mem_wr_en), 0);
        chk({tag, ".addr"}, 32'(mem_addr), 0);
        chk({tag, ".wr_data"}, 32'(mem_wr_data), 0);
        chk({tag, ".upd_all"}, {upd_q ^ upd_max_q ^ upd_reward, 8'd0, upd_gamma, upd_alfa}, 0);
        chk({tag, ".max_q_out"}, 32'(max_q_out), 0);
    endtask

    initial begin
        int wr0, dn0;
        mem[int'({15'h0123, 4'd4})] = 16'd100;
        vals = '{5, -3, 40, 7, 0, 12, 40, 1, 2};
        load_next(15'h0456);
        vals = '{-50, -20, -9, -30, -100, -11, -40, -60, -70};
        load_next(15'h0200);

        #1;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_op("full_mask",  15'h0456, 1'b0, 9'h1FF, 16'd5,     -1, 16'd40,    16'h00C3);
        run_op("mask_0FB",   15'h0456, 1'b0, 9'h0FB, 16'd5,     -1, 16'd40,    16'h00C3);
        run_op("mask_0BB",   15'h0456, 1'b0, 9'h0BB, 16'd5,     -1, 16'd12,    16'h00A7);
        run_op("mask_none",  15'h0456, 1'b0, 9'h000, 16'd5,     -1, 16'h0000,  16'h009B);
        run_op("all_neg",    15'h0200, 1'b0, 9'h1FF, 16'd5,     -1, 16'hFFF7,  16'h0092);
        run_op("terminal",   15'h0456, 1'b1, 9'h1FF, 16'h0100,  -1, 16'h0000,  16'h0196);
        run_op("dbl_start",  15'h0456, 1'b0, 9'h1FF, 16'd5,      5, 16'd40,    16'h00C3);

        // Abort in cycle 8 of a non-terminal operation.
        wr0 = wr_cnt; dn0 = done_cnt;
        drive_start(15'h0123, 4'd4, 15'h0456, 1'b0, 9'h1FF, 16'd5);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort.no_write", wr_cnt - wr0, 0);
        chk("abort.no_done", done_cnt - dn0, 0);
        chk("abort.idle", 32'(busy), 0);

        run_op("recover",    15'h0456, 1'b0, 9'h1FF, 16'd5,     -1, 16'd40,    16'h00C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/q_update_ctrl.md
Q_UPDATE_CTRL -- requirements
Module: q_update_ctrl

Interface
REQ-001 SHALL have parameter SW, default 15, meaning board-state index width; address = {state, action[3:0]}, AW = SW+4.
REQ-002 SHALL have parameter NACT, default 9, meaning number of actions (board cells) scanned per next state.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports start input 1 (request pulse), cur_state input SW, action input 4, next_state input SW, terminal input 1 (next_state is game-over).
REQ-006 SHALL have ports act_mask input 9 (1 = legal action in next_state), reward input 16 (signed), gamma input 4, alfa input 4.
REQ-007 SHALL have ports mem_rd_en output 1, mem_addr output AW, mem_rd_data input 16, mem_wr_en output 1, mem_wr_data output 16.
REQ-008 SHALL have ports upd_q output 16, upd_max_q output 16, upd_reward output 16, upd_gamma output 4, upd_alfa output 4, upd_q_new input 16 (to/from external Q-update datapath).
REQ-009 SHALL have ports busy output 1, done output 1 (one-cycle pulse), max_q_out output 16 (last max used).

Function
REQ-010 SHALL implement states IDLE, RD_Q, SCAN, DRAIN, UPD, WR, DONE.
REQ-011 SHALL, in IDLE with start=1, latch cur_state, action, next_state, terminal, act_mask, reward, gamma, alfa and go to RD_Q; inputs other than mem_rd_data/upd_q_new ignored thereafter.
REQ-012 SHALL ignore start whenever busy=1; busy=1 in every state except IDLE.
REQ-013 SHALL in RD_Q assert mem_rd_en with mem_addr={cur_state,action}; next state SCAN if terminal=0, else DRAIN.
REQ-014 Memory read latency SHALL be exactly one cycle: data for address issued in cycle t captured from mem_rd_data in cycle t+1.
REQ-015 SHALL capture Q in the cycle after RD_Q (first SCAN cycle, or DRAIN when terminal).
REQ-016 SHALL in SCAN issue reads {next_state, a} for a = 0..NACT-1, one per cycle, regardless of mask (fixed latency); exit to DRAIN after a = NACT-1.
REQ-017 SHALL compare each returned scan value as signed 16-bit against a running max initialised to 16'h8000 when act_mask[a]=1, replacing it on strictly greater; masked actions never update it.
REQ-018 SHALL in DRAIN capture the last outstanding read; max_q = running max if any mask bit set, else 16'h0000; max_q = 16'h0000 when terminal.
REQ-019 SHALL in UPD drive upd_q, upd_max_q, upd_reward, upd_gamma, upd_alfa from latched values and register upd_q_new at end of UPD; operands held stable through UPD and WR.
REQ-020 SHALL in WR assert mem_wr_en for exactly one cycle with mem_addr={cur_state,action}, mem_wr_data = registered upd_q_new.
REQ-021 SHALL in DONE pulse done=1 for one cycle, update max_q_out, return to IDLE; start in DONE ignored.
REQ-022 Cycle timing, start sampled in cycle 0: non-terminal RD_Q 1, SCAN 2-10, DRAIN 11, UPD 12, WR 13, DONE 14; terminal RD_Q 1, DRAIN 2, UPD 3, WR 4, DONE 5.
REQ-023 mem_rd_en and mem_wr_en SHALL never be asserted in the same cycle; mem_rd_en=0 outside RD_Q/SCAN.
REQ-024 Next start SHALL be accepted earliest in the cycle after DONE (IDLE).

Reset
REQ-025 rst=1 SHALL immediately force IDLE, busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, all upd_* =0, max_q_out=0, running max=16'h8000.
REQ-026 rst asserted mid-operation SHALL abort with no write issued and no done pulse; operation not resumed after release.

Verification
REQ-027 Non-terminal: Q=100, next-state values {5,-3,40,7,0,12,40,1,2}, mask 9'h1FF -> upd_max_q=40, write at cycle 13 of upd_q_new to {cur_state,action}, done at cycle 14.
REQ-028 Masking: same values, mask 9'h0FB (action 2 illegal) -> upd_max_q=40 via action 6; mask 9'h000 -> upd_max_q=0.
REQ-029 All-negative legal values {-50,...,-9 as max} mask 9'h1FF -> upd_max_q=-9 (16'hFFF7), not 0.
REQ-030 Terminal=1, reward=16'h0100 -> no SCAN reads, upd_max_q=0, write cycle 4, done cycle 5.
REQ-031 start pulsed at cycles 0 and 5 -> second ignored, exactly one write and one done.
REQ-032 rst asserted in cycle 8 of non-terminal op -> all outputs reset within that cycle, mem_wr_en never asserted, done never pulsed; new start after release completes normally.
